// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC multiplexed-bus sequencers (write and read).
package rtc_bus_pkg;

   localparam int unsigned AD_W = 8;

   // Default phase timing, in clk cycles
   localparam int unsigned T_SETUP_DEF  = 2;
   localparam int unsigned T_STROBE_DEF = 3;
   localparam int unsigned T_HOLD_DEF   = 2;
   localparam int unsigned T_REC_DEF    = 2;
   localparam int unsigned CNT_W_DEF    = 8;

   // Bus idle levels
   localparam logic A_D_IDLE        = 1'b1;
   localparam logic STROBE_INACTIVE = 1'b1;

   typedef enum logic [3:0] {
      WR_IDLE,
      WR_ASETUP,
      WR_ASTRB,
      WR_AHOLD,
      WR_DSETUP,
      WR_DSTRB,
      WR_DHOLD,
      WR_RECOV,
      WR_DONE
   } wr_state_e;

   // Timer reload for a dwell of t cycles; a dwell of 0 behaves as 1
   function automatic int unsigned dwell_load(input int unsigned t);
      return (t == 0) ? 0 : t - 1;
   endfunction

endpackage

// File: rtl/rtc_write_seq_if.sv
// Request/status handshake plus RTC bus pins of the write sequencer.
interface rtc_write_seq_if;
   import rtc_bus_pkg::*;

   logic            start;
   logic [AD_W-1:0] addr;
   logic [AD_W-1:0] wdata;
   logic            busy;
   logic            done;
   logic            a_d;
   logic            cs_n;
   logic            rd_n;
   logic            wr_n;
   logic            bus_oe;
   logic [AD_W-1:0] ad_out;

   // Controller side
   modport master (
      output start, addr, wdata,
      input  busy, done, a_d, cs_n, rd_n, wr_n, bus_oe, ad_out
   );

   // Sequencer side
   modport slave (
      input  start, addr, wdata,
      output busy, done, a_d, cs_n, rd_n, wr_n, bus_oe, ad_out
   );

endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter timing one bus phase; expired is high once the count is 0.
module rtc_phase_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Reload on phase entry, otherwise count down and stick at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Count register; expired is registered alongside so it tracks cnt_q exactly
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         expired <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         expired <= (cnt_d == '0);
      end
   end

endmodule

// File: rtl/rtc_write_seq.sv
// RTC write sequencer: address cycle, data cycle, bus recovery, done pulse.
// Optional macro RTC_WR_B2B_EN: allows a new start in DONE (back-to-back writes).
module rtc_write_seq
   import rtc_bus_pkg::*;
#(
   parameter int unsigned T_SETUP  = T_SETUP_DEF,
   parameter int unsigned T_STROBE = T_STROBE_DEF,
   parameter int unsigned T_HOLD   = T_HOLD_DEF,
   parameter int unsigned T_REC    = T_REC_DEF,
   parameter int unsigned CNT_W    = CNT_W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   rtc_write_seq_if.slave bus
);

   localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(dwell_load(T_SETUP));
   localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(dwell_load(T_STROBE));
   localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(dwell_load(T_HOLD));
   localparam logic [CNT_W-1:0] LD_REC    = CNT_W'(dwell_load(T_REC));

   wr_state_e       state_q, state_d;
   logic [AD_W-1:0] addr_q, wdata_q;
   logic [AD_W-1:0] addr_nx, wdata_nx;
   logic            latch_c;
   logic            load_c;
   logic [CNT_W-1:0] load_val_c;
   logic            expired;

   logic            busy_d, done_d, a_d_d, cs_n_d, wr_n_d, bus_oe_d;
   logic [AD_W-1:0] ad_d;

   rtc_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (load_c),
      .load_val (load_val_c),
      .expired  (expired)
   );

   // Next state, timer reload and next output values (outputs follow state_d)
   always_comb begin
      state_d    = state_q;
      latch_c    = 1'b0;
      load_c     = 1'b0;
      load_val_c = '0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      a_d_d      = A_D_IDLE;
      cs_n_d     = STROBE_INACTIVE;
      wr_n_d     = STROBE_INACTIVE;
      bus_oe_d   = 1'b0;
      ad_d       = '0;

      case (state_q)
         WR_IDLE: begin
            if (bus.start) begin
               latch_c = 1'b1;
               state_d = WR_ASETUP;
            end
         end
         WR_ASETUP: if (expired) state_d = WR_ASTRB;
         WR_ASTRB:  if (expired) state_d = WR_AHOLD;
         WR_AHOLD:  if (expired) state_d = WR_DSETUP;
         WR_DSETUP: if (expired) state_d = WR_DSTRB;
         WR_DSTRB:  if (expired) state_d = WR_DHOLD;
         WR_DHOLD:  if (expired) state_d = WR_RECOV;
         WR_RECOV:  if (expired) state_d = WR_DONE;
         WR_DONE: begin
`ifdef RTC_WR_B2B_EN
            if (bus.start) begin
               latch_c = 1'b1;
               state_d = WR_ASETUP;
            end else begin
               state_d = WR_IDLE;
            end
`else
            state_d = WR_IDLE;
`endif
         end
         default: state_d = WR_IDLE;
      endcase

      // Data being latched this edge must already drive the AD lines
      addr_nx  = latch_c ? bus.addr  : addr_q;
      wdata_nx = latch_c ? bus.wdata : wdata_q;

      load_c = (state_d != state_q);

      case (state_d)
         WR_ASETUP: begin
            load_val_c = LD_SETUP;
            busy_d = 1'b1; a_d_d = 1'b0; bus_oe_d = 1'b1; ad_d = addr_nx;
         end
         WR_ASTRB: begin
            load_val_c = LD_STROBE;
            busy_d = 1'b1; a_d_d = 1'b0; bus_oe_d = 1'b1; ad_d = addr_nx;
            cs_n_d = ~STROBE_INACTIVE; wr_n_d = ~STROBE_INACTIVE;
         end
         WR_AHOLD: begin
            load_val_c = LD_HOLD;
            busy_d = 1'b1; a_d_d = 1'b0; bus_oe_d = 1'b1; ad_d = addr_nx;
         end
         WR_DSETUP: begin
            load_val_c = LD_SETUP;
            busy_d = 1'b1; a_d_d = 1'b1; bus_oe_d = 1'b1; ad_d = wdata_nx;
         end
         WR_DSTRB: begin
            load_val_c = LD_STROBE;
            busy_d = 1'b1; a_d_d = 1'b1; bus_oe_d = 1'b1; ad_d = wdata_nx;
            cs_n_d = ~STROBE_INACTIVE; wr_n_d = ~STROBE_INACTIVE;
         end
         WR_DHOLD: begin
            load_val_c = LD_HOLD;
            busy_d = 1'b1; a_d_d = 1'b1; bus_oe_d = 1'b1; ad_d = wdata_nx;
         end
         WR_RECOV: begin
            load_val_c = LD_REC;
            busy_d = 1'b1;
         end
         WR_DONE: begin
            done_d = 1'b1;
`ifdef RTC_WR_B2B_EN
            busy_d = 1'b0;
`else
            busy_d = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   // State, latched request data and registered bus outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= WR_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.a_d    <= A_D_IDLE;
         bus.cs_n   <= STROBE_INACTIVE;
         bus.rd_n   <= STROBE_INACTIVE;
         bus.wr_n   <= STROBE_INACTIVE;
         bus.bus_oe <= 1'b0;
         bus.ad_out <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_nx;
         wdata_q    <= wdata_nx;
         bus.busy   <= busy_d;
         bus.done   <= done_d;
         bus.a_d    <= a_d_d;
         bus.cs_n   <= cs_n_d;
         bus.rd_n   <= STROBE_INACTIVE;
         bus.wr_n   <= wr_n_d;
         bus.bus_oe <= bus_oe_d;
         bus.ad_out <= ad_d;
      end
   end

endmodule

// File: tb/tb_rtc_write_seq.sv
// Directed self-checking bench for rtc_write_seq (default, all-1 and zero-strobe timings).
module tb_rtc_write_seq;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   rtc_write_seq_if bus0();
   rtc_write_seq_if bus1();
   rtc_write_seq_if bus2();

   rtc_write_seq u0 (.clk(clk), .reset(reset), .bus(bus0));

   rtc_write_seq #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1), .T_REC(1), .CNT_W(8))
      u1 (.clk(clk), .reset(reset), .bus(bus1));

   rtc_write_seq #(.T_SETUP(1), .T_STROBE(0), .T_HOLD(1), .T_REC(1), .CNT_W(8))
      u2 (.clk(clk), .reset(reset), .bus(bus2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef RTC_WR_B2B_EN
   localparam logic DONE_BUSY = 1'b0;
`else
   localparam logic DONE_BUSY = 1'b1;
`endif

   // {busy, done, a_d, cs_n, rd_n, wr_n, bus_oe, ad_out}
   function automatic logic [14:0] vec(input logic busy, input logic done, input logic a_d,
                                       input logic strb_n, input logic oe, input logic [7:0] ad);
      return {busy, done, a_d, strb_n, 1'b1, strb_n, oe, ad};
   endfunction

   localparam logic [14:0] IDLE_VEC = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};

   function automatic logic [14:0] obs(input int sel);
      case (sel)
         0: return {bus0.busy, bus0.done, bus0.a_d, bus0.cs_n, bus0.rd_n, bus0.wr_n, bus0.bus_oe, bus0.ad_out};
         1: return {bus1.busy, bus1.done, bus1.a_d, bus1.cs_n, bus1.rd_n, bus1.wr_n, bus1.bus_oe, bus1.ad_out};
         2: return {bus2.busy, bus2.done, bus2.a_d, bus2.cs_n, bus2.rd_n, bus2.wr_n, bus2.bus_oe, bus2.ad_out};
         default: return '0;
      endcase
   endfunction

   // Expected bus state in cycle k after the start edge (cycle 1 follows edge 0)
   function automatic logic [14:0] exp_at(input int k, input int s, input int t, input int h,
                                          input int r, input logic [7:0] a, input logic [7:0] d);
      int ph;
      int n;
      int j;
      ph = s + t + h;
      n  = 2 * ph + r;
      if (k >= 1 && k <= ph) begin
         return vec(1'b1, 1'b0, 1'b0, !(k > s && k <= s + t), 1'b1, a);
      end else if (k > ph && k <= 2 * ph) begin
         j = k - ph;
         return vec(1'b1, 1'b0, 1'b1, !(j > s && j <= s + t), 1'b1, d);
      end else if (k > 2 * ph && k <= n) begin
         return vec(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
      end else if (k == n + 1) begin
         return vec(DONE_BUSY, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
      end
      return IDLE_VEC;
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic drive(input int sel, input logic st, input logic [7:0] a, input logic [7:0] d);
      case (sel)
         0: begin bus0.start = st; bus0.addr = a; bus0.wdata = d; end
         1: begin bus1.start = st; bus1.addr = a; bus1.wdata = d; end
         2: begin bus2.start = st; bus2.addr = a; bus2.wdata = d; end
         default: ;
      endcase
   endtask

   // One write on DUT sel; addr/wdata are zeroed right after the start edge
   task automatic txn(input int tn, input int sel, input int s, input int t, input int h, input int r,
                      input logic [7:0] a, input logic [7:0] d, input bit reissue);
      int n;
      n = 2 * (s + t + h) + r;
      @(negedge clk);
      drive(sel, 1'b1, a, d);
      @(posedge clk);
      #1 drive(sel, 1'b0, 8'h00, 8'h00);
      for (int k = 1; k <= n + 4; k++) begin
         @(negedge clk);
         chk($sformatf("t%0d_c%0d", tn, k), 32'(obs(sel)), 32'(exp_at(k, s, t, h, r, a, d)));
         if (reissue && k == 5) drive(sel, 1'b1, 8'hFF, 8'hEE);
         if (reissue && k == 6) drive(sel, 1'b0, 8'h00, 8'h00);
      end
   endtask

   initial begin
      int  n;
      int  cnt;
      bit  seen;
      total = 0;
      bad   = 0;
      reset = 1'b1;
      drive(0, 1'b0, 8'h00, 8'h00);
      drive(1, 1'b0, 8'h00, 8'h00);
      drive(2, 1'b0, 8'h00, 8'h00);

      // Reset values
      @(negedge clk);
      chk("reset_u0", 32'(obs(0)), 32'(IDLE_VEC));
      chk("reset_u1", 32'(obs(1)), 32'(IDLE_VEC));
      @(negedge clk);
      reset = 1'b0;

      // Default timing, addr/wdata cleared after the start edge
      txn(1, 0, 2, 3, 2, 2, 8'h21, 8'h45, 1'b0);
      // All timings 1: done in cycle 8
      txn(2, 1, 1, 1, 1, 1, 8'hA5, 8'h5A, 1'b0);
      // T_STROBE=0 behaves like 1
      txn(3, 2, 1, 1, 1, 1, 8'h3C, 8'hC3, 1'b0);
      // start while busy is ignored
      txn(4, 0, 2, 3, 2, 2, 8'h21, 8'h45, 1'b1);

      // Reset in the first DSTRB cycle (cycle 10)
      @(negedge clk);
      drive(0, 1'b1, 8'h21, 8'h45);
      @(posedge clk);
      #1 drive(0, 1'b0, 8'h00, 8'h00);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 10) chk("rst_pre_dstrb", 32'(obs(0)), 32'(vec(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h45)));
      end
      reset = 1'b1;
      #1 chk("rst_immediate", 32'(obs(0)), 32'(IDLE_VEC));
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk($sformatf("rst_quiet_c%0d", k), 32'(obs(0)), 32'(IDLE_VEC));
      end
      txn(5, 0, 2, 3, 2, 2, 8'h12, 8'h34, 1'b0);

      // start held high through DONE
      n = 16;
      @(negedge clk);
      drive(0, 1'b1, 8'h30, 8'h31);
      @(posedge clk);
      for (int k = 1; k <= n + 3; k++) begin
         @(negedge clk);
`ifdef RTC_WR_B2B_EN
         if (k <= n + 1)
            chk($sformatf("b2b_c%0d", k), 32'(obs(0)), 32'(exp_at(k, 2, 3, 2, 2, 8'h30, 8'h31)));
         else
            chk($sformatf("b2b_c%0d", k), 32'(obs(0)), 32'(vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h30)));
`else
         if (k <= n + 2)
            chk($sformatf("b2b_c%0d", k), 32'(obs(0)), 32'(exp_at(k, 2, 3, 2, 2, 8'h30, 8'h31)));
         else
            chk($sformatf("b2b_c%0d", k), 32'(obs(0)), 32'(vec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h30)));
`endif
      end
      drive(0, 1'b0, 8'h00, 8'h00);
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 60) begin
         @(negedge clk);
         cnt++;
         if (bus0.done === 1'b1) seen = 1'b1;
      end
      chk("b2b_second_done", 32'(seen), 32'd1);
      @(negedge clk);
      chk("b2b_idle_after", 32'(obs(0)), 32'(IDLE_VEC));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
